// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Brief   : Shared load-type codes and the outstanding-load queue entry used
//           by the MIPS I register-file write-port controller.
// Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Load type codes carried with each issued load
  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  // One outstanding load: destination, type, byte offset, and the returned
  // word once the memory response has arrived
  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        has_data;
  } ld_entry_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_load_align.sv
`default_nettype none
// ============================================================================
// Module  : mips_load_align
// Brief   : Little-endian load alignment. Turns an aligned memory word plus
//           load type and byte offset into register-file byte enables and
//           write data. Purely combinational.
// Rev     : 1.0  initial release
// ============================================================================
module mips_load_align
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  we,
  output logic [31:0] wr_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [1:0]  lwl_shift;

  // Select the addressed byte/half and build lane enables and data per type
  always_comb begin
    sel_byte  = data[{addr, 3'b000} +: 8];
    sel_half  = addr[1] ? data[31:16] : data[15:0];
    lwl_shift = 2'd3 - addr;
    we        = 4'b1111;
    wr_data   = data;
    case (op)
      LD_LW:  wr_data = data;
      LD_LB:  wr_data = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU: wr_data = {24'd0, sel_byte};
      LD_LH:  wr_data = {{16{sel_half[15]}}, sel_half};
      LD_LHU: wr_data = {16'd0, sel_half};
      // LWL fills the upper lanes from the low end of the word
      LD_LWL: begin
        we      = 4'b1111 << lwl_shift;
        wr_data = data << {lwl_shift, 3'b000};
      end
      // LWR fills the lower lanes from the high end of the word
      LD_LWR: begin
        we      = 4'b1111 >> addr;
        wr_data = data >> {addr, 3'b000};
      end
      default: begin
        we      = 4'b0000;
        wr_data = data;
      end
    endcase
  end

endmodule : mips_load_align
`default_nettype wire

// File: rtl/mips_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips_wb_ctrl
// Brief   : Register-file write-port controller. Arbitrates the single write
//           port between ALU results and in-order load returns, queues
//           outstanding loads, and raises decode stall on pending hazards.
// Rev     : 1.0  initial release
// ============================================================================
module mips_wb_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_addr,
  output logic        ld_ready,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  wd,
  input  logic        wd_is_load,
  output logic        stall,
  output logic [4:0]  rd,
  output logic [3:0]  we,
  output logic [31:0] D
);

  localparam int PTR_W = $clog2(DEPTH);

  ld_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [PTR_W-1:0]      fill_q, fill_d;
  logic [PTR_W:0]        count_q, count_d;

  ld_entry_t   head_ent;
  logic        head_ready;
  logic        ld_accept;
  logic        pop;
  logic        fill_hit;
  logic [3:0]  al_we;
  logic [31:0] al_data;

  // Align the head entry; only used when the head is selected for writing
  mips_load_align u_align (
    .op      (head_ent.op),
    .addr    (head_ent.addr),
    .data    (head_ent.data),
    .we      (al_we),
    .wr_data (al_data)
  );

  // Queue status: head readiness, acceptance, and whether a response can land.
  // The fill pointer sits on the oldest data-less entry whenever one exists.
  always_comb begin
    head_ent   = ent_q[head_q];
    head_ready = valid_q[head_q] && head_ent.has_data;
    ld_ready   = (count_q < (PTR_W + 1)'(DEPTH));
    ld_accept  = ld_issue && ld_ready;
    pop        = !alu_valid && head_ready;
    fill_hit   = mem_valid && valid_q[fill_q] && !ent_q[fill_q].has_data;
  end

  // Write-port select: ALU first, then a completed head load, else idle
  always_comb begin
    rd = 5'd0;
    we = 4'b0000;
    D  = 32'd0;
    if (alu_valid) begin
      rd = alu_rd;
      we = 4'b1111;
      D  = alu_data;
    end else if (head_ready) begin
      rd = head_ent.rd;
      we = al_we;
      D  = al_data;
    end
    // r0 is hardwired; loads to r0 still pop to keep response order intact
    if (rd == 5'd0) begin
      we = 4'b0000;
    end
  end

  // Stall on any valid entry whose destination matches a decode operand;
  // a load-to-same-destination is ordered by the queue and needs no stall
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (ent_q[i].rd != 5'd0) &&
          ((ent_q[i].rd == rs) || (ent_q[i].rd == rt) ||
           ((ent_q[i].rd == wd) && !wd_is_load))) begin
        stall = 1'b1;
      end
    end
  end

  // Queue next state: response fill, head pop and tail push can coincide;
  // they never touch the same slot (fill/pop need a valid slot, push a free one)
  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;

    if (fill_hit) begin
      ent_d[fill_q].data     = mem_data;
      ent_d[fill_q].has_data = 1'b1;
      fill_d                 = fill_q + PTR_W'(1);
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    if (ld_accept) begin
      ent_d[tail_q].rd       = ld_rd;
      ent_d[tail_q].op       = ld_op;
      ent_d[tail_q].addr     = ld_addr;
      ent_d[tail_q].data     = 32'd0;
      ent_d[tail_q].has_data = 1'b0;
      valid_d[tail_q]        = 1'b1;
      tail_d                 = tail_q + PTR_W'(1);
    end

    case ({ld_accept, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards every entry and in-flight data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_q   <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

endmodule : mips_wb_ctrl
`default_nettype wire

// File: tb/tb_mips_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_wb_ctrl
// Brief   : Self-checking bench for mips_wb_ctrl. A transaction-level model
//           predicts each cycle's port outputs into a scoreboard queue; a
//           negedge monitor pops and compares against the DUT.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mips_wb_ctrl;
  import mips_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid, ld_issue, mem_valid, wd_is_load;
  logic [4:0]  alu_rd, ld_rd, rs, rt, wd;
  logic [31:0] alu_data, mem_data;
  logic [2:0]  ld_op;
  logic [1:0]  ld_addr;
  logic        ld_ready, stall;
  logic [4:0]  rd;
  logic [3:0]  we;
  logic [31:0] D;

  always #5 clock = ~clock;

  mips_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_op(ld_op), .ld_addr(ld_addr),
    .ld_ready(ld_ready),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .rs(rs), .rt(rt), .wd(wd), .wd_is_load(wd_is_load),
    .stall(stall), .rd(rd), .we(we), .D(D)
  );

  // Model of outstanding loads, oldest first
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  op;
    logic [1:0]  a;
    logic [31:0] data;
    bit          has;
  } mload_t;
  mload_t mq[$];

  // Expected outputs for one cycle
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [3:0]  we;
    logic [31:0] d;
    logic        stall;
    logic        ready;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
  endtask

  // Little-endian load semantics expressed lane by lane
  task automatic model_align(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w,
                             output logic [3:0] mwe, output logic [31:0] md);
    int b[4];
    int v, sh, ai, hi;
    for (int k = 0; k < 4; k++) b[k] = int'(w[8*k +: 8]);
    ai  = int'(a);
    hi  = a[1] ? 2 : 0;
    mwe = 4'b1111;
    md  = 32'd0;
    case (op)
      LD_LW:  md = w;
      LD_LB:  begin v = b[ai]; if (v >= 128) v = v - 256; md = 32'(v); end
      LD_LBU: md = 32'(b[ai]);
      LD_LH:  begin v = b[hi] + 256 * b[hi+1]; if (v >= 32768) v = v - 65536; md = 32'(v); end
      LD_LHU: md = 32'(b[hi] + 256 * b[hi+1]);
      LD_LWL: begin
        sh = 3 - ai;
        for (int k = 0; k < 4; k++) begin
          mwe[k] = (k >= sh);
          if (k >= sh) md[8*k +: 8] = 8'(b[k-sh]);
        end
      end
      LD_LWR: begin
        for (int k = 0; k < 4; k++) begin
          mwe[k] = (k <= 3 - ai);
          if (k <= 3 - ai) md[8*k +: 8] = 8'(b[k+ai]);
        end
      end
      default: begin mwe = 4'b0000; md = w; end
    endcase
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_rd = 0; ld_op = LD_LW; ld_addr = 0;
    mem_valid = 0; mem_data = 0;
    rs = 0; rt = 0; wd = 0; wd_is_load = 0;
  endtask

  // Predict this cycle from current inputs, advance the model, then move on
  // to the next cycle (#1 after the next rising edge)
  task automatic tick();
    exp_t   e;
    mload_t t;
    logic [3:0]  mwe;
    logic [31:0] md;
    bit pop;
    if (reset) mq.delete();
    e.cyc   = cyc;
    e.ready = (mq.size() < DEPTH);
    e.stall = 1'b0;
    foreach (mq[i])
      if (mq[i].rd != 0 && (mq[i].rd == rs || mq[i].rd == rt || (mq[i].rd == wd && !wd_is_load)))
        e.stall = 1'b1;
    pop = 0;
    if (alu_valid) begin
      e.rd = alu_rd; e.we = 4'hF; e.d = alu_data;
    end else if (mq.size() > 0 && mq[0].has) begin
      model_align(mq[0].op, mq[0].a, mq[0].data, mwe, md);
      e.rd = mq[0].rd; e.we = mwe; e.d = md; pop = 1;
    end else begin
      e.rd = 0; e.we = 0; e.d = 0;
    end
    if (e.rd == 0) e.we = 0;
    sb.push_back(e);
    if (!reset) begin
      if (mem_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].has) begin
            t = mq[i]; t.data = mem_data; t.has = 1; mq[i] = t;
            break;
          end
        end
      end
      if (pop) t = mq.pop_front();
      if (ld_issue && e.ready) begin
        t.rd = ld_rd; t.op = ld_op; t.a = ld_addr; t.data = 0; t.has = 0;
        mq.push_back(t);
      end
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  // Monitor: one expected record per cycle, compared away from the edge
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty cycle=%0d actual=none required=record", cyc);
      end else begin
        e = sb.pop_front();
        chk("ld_ready", 32'(ld_ready), 32'(e.ready));
        chk("stall",    32'(stall),    32'(e.stall));
        chk("rd",       32'(rd),       32'(e.rd));
        chk("we",       32'(we),       32'(e.we));
        chk("D",        D,             e.d);
      end
    end
  end

  task automatic issue(input logic [4:0] r, input logic [2:0] op, input logic [1:0] a);
    ld_issue = 1; ld_rd = r; ld_op = op; ld_addr = a;
  endtask

  task automatic respond(input logic [31:0] w);
    mem_valid = 1; mem_data = w;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clock); #1;
    mon_en = 1;
    tick();                                   // reset state
    reset = 0;

    // ALU writes, including r0
    idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'h12345678; tick();
    idle(); alu_valid = 1; alu_rd = 0; alu_data = 32'h12345678; tick();

    // LB / LBU at byte 3
    idle(); issue(4, LD_LB, 2'd3); tick();
    idle(); respond(32'h80FF_0000); rs = 4; tick();
    idle(); rs = 4; tick();
    idle(); rs = 4; tick();
    idle(); issue(4, LD_LBU, 2'd3); tick();
    idle(); respond(32'h80FF_0000); tick();
    idle(); tick();

    // LWL/LWR pair to r7, no stall between issues
    idle(); issue(7, LD_LWL, 2'd1); tick();
    idle(); issue(7, LD_LWR, 2'd1); wd = 7; wd_is_load = 1; tick();
    idle(); respond(32'hAABBCCDD); tick();
    idle(); respond(32'h11223344); tick();
    idle(); tick();
    idle(); tick();

    // Response collides with ALU write
    idle(); issue(9, LD_LW, 2'd0); tick();
    idle(); rs = 9; respond(32'hCAFEF00D); alu_valid = 1; alu_rd = 3; alu_data = 32'h0BAD_BEEF; tick();
    idle(); rs = 9; tick();
    idle(); rs = 9; tick();

    // Fill the queue, refuse a third issue, drain in order
    idle(); issue(10, LD_LW, 2'd0); tick();
    idle(); issue(11, LD_LHU, 2'd2); tick();
    idle(); issue(12, LD_LW, 2'd0); tick();
    idle(); respond(32'h0102_0304); tick();
    idle(); respond(32'hF00D_8001); tick();
    idle(); tick();
    idle(); tick();

    // Reset with an entry pending, then a stale response
    idle(); issue(13, LD_LW, 2'd0); tick();
    idle(); reset = 1; tick();
    reset = 0;
    idle(); respond(32'hDEAD_BEEF); rs = 13; tick();
    idle(); tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset      = ($urandom_range(0, 199) == 0);
      alu_valid  = !reset && ($urandom_range(0, 9) < 4);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      ld_issue   = ($urandom_range(0, 9) < 4);
      ld_rd      = 5'($urandom_range(0, 7));
      ld_op      = 3'($urandom_range(0, 6));
      ld_addr    = 2'($urandom_range(0, 3));
      mem_valid  = ($urandom_range(0, 9) < 5);
      mem_data   = $urandom;
      rs         = 5'($urandom_range(0, 7));
      rt         = 5'($urandom_range(0, 7));
      wd         = 5'($urandom_range(0, 7));
      wd_is_load = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 0;
    idle();
    mon_en = 0;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mips_wb_ctrl
`default_nettype wire

// File: doc/mips_wb_ctrl.md
# mips_wb_ctrl

Write-port controller for the MIPS I register file. Owns the single write port (rd, we[3:0], D) and shares it between the ALU result path and in-order memory load returns. Converts load responses into byte-lane writes (LB/LBU/LH/LHU/LW/LWL/LWR, little-endian). Tracks outstanding loads and stalls decode on any hazard against a pending destination.

## Interface
Parameters:
- DEPTH, 2: outstanding-load queue entries (power of two, ≥2).

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_issue  in  1  load issued to memory this cycle.
- ld_rd  in  5  load destination register.
- ld_op  in  3  load type (package codes).
- ld_addr  in  2  byte address bits [1:0].
- ld_ready  out  1  queue can accept ld_issue (count < DEPTH).
- mem_valid  in  1  memory response this cycle; responses arrive in issue order; no backpressure.
- mem_data  in  32  aligned memory word.
- rs, rt  in  5  decode source registers.
- wd  in  5  decode destination register.
- wd_is_load  in  1  decode instruction is a load.
- stall  out  1  decode must hold.
- rd  out  5  register-file write address.
- we  out  4  register-file byte write enables.
- D  out  32  register-file write data.

## Operation
- Queue entry: rd, op, addr, data, has_data. In-order FIFO with head, tail and fill pointers plus a count.
- ld_issue with ld_ready=1 pushes at tail with has_data=0. ld_issue with ld_ready=0 is ignored; no state change.
- mem_valid writes mem_data into the oldest entry with has_data=0 and sets has_data. If no such entry exists, the response is dropped.
- Write-port select (combinational), in priority order:
  - alu_valid: rd=alu_rd, D=alu_data, we=1111.
  - Otherwise, if head has_data: drive the aligned head entry and pop it at the clock edge.
  - Otherwise: we=0000, rd=0, D=0.
- rd=0 forces we=0000. A load to r0 is still queued and popped, which preserves response order.
- Alignment, a=addr:
  - LW: we=1111, D=data.
  - LB/LBU: byte a, sign- or zero-extended to 32 bits, we=1111.
  - LH/LHU: half a[1], sign- or zero-extended, we=1111.
  - LWL: we has bits 3 down to 3−a set; D=data<<(8·(3−a)).
  - LWR: we has bits 0 up to 3−a set; D=data>>(8·a).
- stall = OR over valid entries with entry.rd≠0 of:
  - entry.rd==rs, or
  - entry.rd==rt, or
  - entry.rd==wd with wd_is_load=0.
- Load-after-load to the same destination does not stall; queue order preserves write order. This covers the LWL/LWR pair idiom.
- An entry being popped this cycle still counts toward stall, because the file write lands at this edge.

## Timing
- Reset: queue empty. Outputs: ld_ready=1, stall=0; rd=0, we=0, D=0 while alu_valid=0.
- ALU write: zero latency; it goes to the file at the edge ending the same cycle.
- Load issued in cycle N:
  - Stall-visible from N+1.
  - Earliest response is N+1. A response in cycle N is dropped if no data-less entry exists.
  - Earliest file write is N+2, when alu_valid=0.
  - stall releases in N+3.
- Response and drain in the same cycle: the head pops and the other entry fills; both happen.
- Issue and pop in the same cycle: count is unchanged. ld_ready uses the pre-edge count, so a full queue refuses issue even while draining.
- Continuous alu_valid starves drain. The queue fills, and the front end stalls via ld_ready.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards all entries and in-flight data. Later mem_valid responses are dropped until new issues.

## Structure
- Shared package mips_pkg holds:
  - LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU, LD_LWL, LD_LWR (3-bit codes).
  - Queue entry typedef.
- Sub-module mips_load_align (combinational): op, addr, data → we, D. Reused by the later big-endian variant.

## Test plan
- Reset, then alu_valid with alu_rd=5, data 0x12345678 → same cycle rd=5, we=1111, D=0x12345678. Repeat with alu_rd=0 → we=0000.
- LB a=3 to r4, response 0x80FF_0000 → D=0xFFFFFF80, we=1111. LBU same → D=0x00000080.
- LWL a=1 then LWR a=1, both to r7, responses 0xAABBCCDD / 0x11223344:
  - No stall between the issues.
  - Writes: we=1100, D=0xCCDD0000, then we=0111, D=0x00112233.
- Load to r9 pending, response and alu_valid both present in cycle N:
  - ALU writes in N; load writes in N+1.
  - stall (rs=9) is high through N+1 and low in N+2.
- DEPTH=2: two issues with no response → ld_ready=0, and a third issue is ignored. Two responses drain in order; ld_ready returns to 1 after the first pop.
- Assert reset with one entry pending, then mem_valid → no write, stall=0, ld_ready=1.
